vit_bmc_acs_ctrl: RTL and testbench

//  Sequencer for the hard-decision Viterbi BMC/ACS array. Accepts received 2-bit symbol pairs on a valid/ready stream.

---
 rtl/vit_bmc_acs_ctrl_pkg.sv | 36 +++
 rtl/vit_frame_cnt.sv | 57 +++++
 rtl/vit_bmc_acs_ctrl.sv | 145 ++++++++++++++
 tb/tb_vit_bmc_acs_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_bmc_acs_ctrl_pkg.sv
// Shared definitions for the hard-decision Viterbi BMC/ACS sequencer:
// controller state encoding, symbol-pair width, the registered strobe
// bundle and the initial path-metric convention shared with the ACS array.
package vit_bmc_acs_ctrl_pkg;

    // Received symbol pair {b1,b0}
    localparam int PAIR_W = 2;

    // Width of the optional per-frame normalization counter
    localparam int NORM_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_TB    = 3'd4
    } state_e;

    // Single-cycle strobes launched from the same register stage
    typedef struct packed {
        logic acs_en;
        logic pm_norm;
        logic tb_start;
    } strobe_t;

    // Metric loaded into ACS state `state_idx` on pm_init: the known start
    // state 0 begins at zero, every other state at the largest W-bit value.
    function automatic logic [31:0] pm_init_metric(input int unsigned state_idx,
                                                   input int unsigned w);
        logic [31:0] max_val;
        max_val = (32'd1 << w) - 32'd1;
        return (state_idx == 0) ? 32'd0 : max_val;
    endfunction

endpackage

// File: rtl/vit_frame_cnt.sv
// Frame position counters for the Viterbi sequencer.
// sym_cnt is the symbol index inside the frame and doubles as the survivor
// write address; wrap flags the last symbol. gap_cnt enforces the minimum
// spacing of ACS_CYC cycles between ACS steps.
module vit_frame_cnt #(
    parameter int FRAME_LEN = 64,
    parameter int ACS_CYC   = 1,
    localparam int AW       = $clog2(FRAME_LEN),
    localparam int GW       = (ACS_CYC > 1) ? $clog2(ACS_CYC) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [AW-1:0] sym_cnt,
    output logic          wrap,
    output logic          gap_zero
);

    logic [AW-1:0] sym_cnt_q, sym_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    // Next counter values: clear at frame start, advance on each accepted pair
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        sym_cnt_d = sym_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (clr) begin
            sym_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (step) begin
            sym_cnt_d = wrap ? '0 : sym_cnt_q + 1'b1;
            gap_cnt_d = GW'(ACS_CYC - 1);
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            sym_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign sym_cnt  = sym_cnt_q;
    assign wrap     = (sym_cnt_q == AW'(FRAME_LEN - 1));
    assign gap_zero = (gap_cnt_q == '0);

endmodule

// File: rtl/vit_bmc_acs_ctrl.sv
// Sequencer for the hard-decision Viterbi BMC/ACS array.
// Accepts symbol pairs on a valid/ready stream, broadcasts each pair to the
// BMC instances, strobes the ACS step with the survivor write address,
// schedules path-metric normalization one step behind the metric update,
// and hands each completed frame to the traceback engine.
// Optional feature: define VIT_NORM_CNT_EN to add the norm_cnt port, a
// saturating count of normalization strobes in the current frame.
module vit_bmc_acs_ctrl
    import vit_bmc_acs_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int ACS_CYC   = 1,
    localparam int AW       = $clog2(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAIR_W-1:0]     in_pair,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PAIR_W-1:0]     bmc_rx_pair,
    output logic                  acs_en,
    output logic                  pm_init,
    input  logic                  pm_msb_any,
    output logic                  pm_norm,
    output logic                  dec_wr_en,
    output logic [AW-1:0]         dec_wr_addr,
    output logic                  tb_start,
    input  logic                  tb_done,
`ifdef VIT_NORM_CNT_EN
    output logic [NORM_CNT_W-1:0] norm_cnt,
`endif
    output logic                  busy
);

    state_e              state_q, state_d;
    logic                fire;
    logic [AW-1:0]       sym_cnt;
    logic                sym_wrap;
    logic                gap_zero;

    strobe_t             strb_q, strb_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic [AW-1:0]       addr_q, addr_d;

    vit_frame_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .ACS_CYC   (ACS_CYC)
    ) u_frame_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (pm_init),
        .step     (fire),
        .sym_cnt  (sym_cnt),
        .wrap     (sym_wrap),
        .gap_zero (gap_zero)
    );

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_INIT;
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (fire && sym_wrap) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_TB;
            // The tb_done level may still be high from the previous frame
            // while tb_start is out, so it only counts from the next cycle.
            ST_TB:    if (!strb_q.tb_start && tb_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: handshake, frame-start strobe and next registered strobes
    always_comb begin
        in_ready = (state_q == ST_RUN) && gap_zero;
        pm_init  = (state_q == ST_INIT);
        busy     = (state_q != ST_IDLE);
        fire     = in_valid && in_ready;

        // pm_msb_any reflects metrics registered by the previous step, so the
        // clear lands one step late; the ACS metric width carries a spare bit
        // to absorb that growth.
        strb_d.acs_en   = fire;
        strb_d.pm_norm  = fire && pm_msb_any;
        strb_d.tb_start = (state_q == ST_DRAIN);

        pair_d = fire ? in_pair : pair_q;
        addr_d = fire ? sym_cnt : addr_q;
    end

    // Registered step outputs; the pair and address hold between steps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q <= '0;
            pair_q <= '0;
            addr_q <= '0;
        end else begin
            strb_q <= strb_d;
            pair_q <= pair_d;
            addr_q <= addr_d;
        end
    end

    assign bmc_rx_pair = pair_q;
    assign acs_en      = strb_q.acs_en;
    assign dec_wr_en   = strb_q.acs_en;
    assign pm_norm     = strb_q.pm_norm;
    assign tb_start    = strb_q.tb_start;
    assign dec_wr_addr = addr_q;

`ifdef VIT_NORM_CNT_EN
    logic [NORM_CNT_W-1:0] norm_cnt_q, norm_cnt_d;

    // Count normalization strobes per frame, saturating; held through TB
    always_comb begin
        norm_cnt_d = norm_cnt_q;
        if (pm_init) begin
            norm_cnt_d = '0;
        end else if (strb_d.pm_norm && (norm_cnt_q != '1)) begin
            norm_cnt_d = norm_cnt_q + 1'b1;
        end
    end

    // Normalization counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            norm_cnt_q <= '0;
        end else begin
            norm_cnt_q <= norm_cnt_d;
        end
    end

    assign norm_cnt = norm_cnt_q;
`endif

endmodule

// File: tb/tb_vit_bmc_acs_ctrl.sv
// Self-checking bench for vit_bmc_acs_ctrl. A driver issues symbol pairs and
// pushes the expected ACS step / traceback hand-off into scoreboard queues;
// monitors pop and compare whenever the DUT presents a strobe. A second
// instance with ACS_CYC=3 runs free to exercise the step spacing.
module tb_vit_bmc_acs_ctrl;

    localparam int FL = 4;
    localparam int AWT = $clog2(FL);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] in_pair = 2'b00;
    logic       in_valid = 1'b0;
    logic       pm_msb_any = 1'b0;
    logic       tb_done = 1'b0;

    logic           in_ready, acs_en, pm_init, pm_norm, dec_wr_en, tb_start, busy;
    logic [1:0]     bmc_rx_pair;
    logic [AWT-1:0] dec_wr_addr;

    logic           c3_in_ready, c3_acs_en, c3_pm_init, c3_pm_norm, c3_dec_wr_en, c3_tb_start, c3_busy;
    logic [1:0]     c3_bmc_rx_pair;
    logic [AWT-1:0] c3_dec_wr_addr;
`ifdef VIT_NORM_CNT_EN
    logic [7:0]     norm_cnt, c3_norm_cnt;
`endif

    vit_bmc_acs_ctrl #(.FRAME_LEN(FL), .ACS_CYC(1)) u_dut (
        .clk(clk), .rst(rst), .in_pair(in_pair), .in_valid(in_valid), .in_ready(in_ready),
        .bmc_rx_pair(bmc_rx_pair), .acs_en(acs_en), .pm_init(pm_init), .pm_msb_any(pm_msb_any),
        .pm_norm(pm_norm), .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr), .tb_start(tb_start),
        .tb_done(tb_done),
`ifdef VIT_NORM_CNT_EN
        .norm_cnt(norm_cnt),
`endif
        .busy(busy)
    );

    vit_bmc_acs_ctrl #(.FRAME_LEN(FL), .ACS_CYC(3)) u_dut_c3 (
        .clk(clk), .rst(rst), .in_pair(2'b10), .in_valid(1'b1), .in_ready(c3_in_ready),
        .bmc_rx_pair(c3_bmc_rx_pair), .acs_en(c3_acs_en), .pm_init(c3_pm_init), .pm_msb_any(1'b0),
        .pm_norm(c3_pm_norm), .dec_wr_en(c3_dec_wr_en), .dec_wr_addr(c3_dec_wr_addr),
        .tb_start(c3_tb_start), .tb_done(1'b1),
`ifdef VIT_NORM_CNT_EN
        .norm_cnt(c3_norm_cnt),
`endif
        .busy(c3_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one entry per accepted pair, plus frame hand-offs
    typedef struct {
        logic [1:0] pair;
        int         addr;
        logic       norm;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   tb_q[$];
    int   tbn_q[$];
    int   sym_idx = 0;
    int   norm_model = 0;
    int   frames_seen = 0;
    bit   pm_init_seen = 1'b0;
    exp_t mon_e;

    // Hold a pair on the stream until accepted; record the expected response
    task automatic send(input logic [1:0] p, input logic m, input logic td, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_pair = p;
        pm_msb_any = m;
        tb_done = td;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        check("send_accepted", ok, 1);
        if (ok) begin
            sb_q.push_back('{pair: p, addr: sym_idx, norm: m, cyc: cyc});
            if (m && norm_model < 255) norm_model++;
            if (sym_idx == FL - 1) begin
                tb_q.push_back(cyc + 2);
                tbn_q.push_back(norm_model);
                norm_model = 0;
                sym_idx = 0;
            end else begin
                sym_idx++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_acs_en"}, acs_en, 0);
        check({tag, "_pm_init"}, pm_init, 0);
        check({tag, "_pm_norm"}, pm_norm, 0);
        check({tag, "_dec_wr_en"}, dec_wr_en, 0);
        check({tag, "_tb_start"}, tb_start, 0);
        check({tag, "_bmc_rx_pair"}, bmc_rx_pair, 0);
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            tb_q.delete();
            tbn_q.delete();
            pm_init_seen = 1'b0;
        end else begin
            if (pm_init) pm_init_seen = 1'b1;
            if (acs_en) begin
                if (sb_q.size() == 0) begin
                    check("acs_en_unexpected", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("bmc_rx_pair", bmc_rx_pair, mon_e.pair);
                    check("dec_wr_addr", dec_wr_addr, mon_e.addr);
                    check("pm_norm", pm_norm, mon_e.norm);
                    check("acs_latency", cyc - mon_e.cyc, 1);
                    check("dec_wr_en", dec_wr_en, 1);
                    if (mon_e.addr == 0) begin
                        check("pm_init_before_frame", pm_init_seen, 1);
                        pm_init_seen = 1'b0;
                    end
                end
            end else begin
                check("pm_norm_idle", pm_norm, 0);
                check("dec_wr_en_idle", dec_wr_en, 0);
            end
            if (tb_start) begin
                if (tb_q.size() == 0) begin
                    check("tb_start_unexpected", 1, 0);
                end else begin
                    check("tb_start_cycle", cyc, tb_q.pop_front());
                    frames_seen++;
`ifdef VIT_NORM_CNT_EN
                    check("norm_cnt", norm_cnt, tbn_q.pop_front());
`else
                    void'(tbn_q.pop_front());
`endif
                end
            end
        end
    end

    // Monitor for the ACS_CYC=3 instance, whose in_valid is tied high
    int c3_last = 0;
    int c3_idx = 0;
    int c3_fires = 0;
    always @(negedge clk) begin
        if (rst) begin
            c3_idx = 0;
        end else begin
            if (c3_acs_en) check("c3_acs_latency", cyc - c3_last, 1);
            if (c3_in_ready) begin
                if (c3_idx != 0) check("c3_fire_spacing", cyc - c3_last, 3);
                c3_last = cyc;
                c3_idx = (c3_idx + 1) % FL;
                c3_fires++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    logic [1:0] dir_pair [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic       dir_msb  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int w;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check_zero("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back frame 11,01,10,00 with normalization request on the 2nd step
        for (int i = 0; i < FL; i++) begin
            send(dir_pair[i], dir_msb[i], 1'b0, w);
            check((i == 0) ? "first_fire_wait" : "b2b_fire_wait", w, (i == 0) ? 2 : 0);
        end

        // Traceback not finished: stream must stay stalled
        in_valid = 1'b1;
        tb_done = 1'b0;
        pm_msb_any = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("tb_hold_in_ready", in_ready, 0);
            check("tb_hold_busy", busy, 1);
        end
        @(posedge clk);
        #1;

        // tb_done releases: TB -> IDLE -> INIT -> first accept, addr restarts at 0
        for (int i = 0; i < FL; i++) begin
            send(2'($urandom_range(0, 3)), 1'b0, 1'b1, w);
            if (i == 0) check("restart_fire_wait", w, 3);
        end
        in_valid = 1'b0;
        idle_cycles(4);

        // Random gaps over three frames
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < FL; s++) begin
                in_valid = 1'b0;
                tb_done = 1'($urandom_range(0, 1));
                idle_cycles($urandom_range(0, 3));
                send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, w);
            end
        end
        in_valid = 1'b0;
        idle_cycles(6);

        // Reset in RUN aborts the frame without a hand-off
        send(2'b01, 1'b0, 1'b1, w);
        send(2'b10, 1'b1, 1'b1, w);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("rst_mid_frame");
        sym_idx = 0;
        norm_model = 0;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(10);
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        @(posedge clk);
        #1;

        // Fresh frame after the abort
        for (int i = 0; i < FL; i++) begin
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, w);
        end
        in_valid = 1'b0;
        idle_cycles(8);

        check("frames_handed_off", frames_seen, 6);
        check("scoreboard_drained", sb_q.size(), 0);
        check("tb_start_drained", tb_q.size(), 0);
        check("c3_fire_count_min", (c3_fires >= 8) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
